// File: rtl/therm_stim_gen.sv
// rtl/therm_stim_gen.sv - thermometer-code stimulus generator for the flash-ADC encoder
// Produces direct, ramp or triangle thermometer patterns with optional single-bit bubble injection.
module therm_stim_gen #(
  parameter int N      = 4,
  parameter int W      = 2**N-1,
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic [N-1:0]      in_code,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HOLD_W-1:0] hold,
  input  logic              bubble_en,
  input  logic [N-1:0]      bubble_pos,
  output logic [W-1:0]      Y,
  output logic              y_valid,
  output logic [N-1:0]      exp_code,
  output logic              bubble_flag,
  output logic              busy,
  output logic              sweep_done
);

  localparam logic [N-1:0] CODE_MAX = N'(W);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_HOLD, S_DONE} state_t;
  typedef enum logic [1:0] {K_DIRECT, K_RAMP, K_TRI} kind_t;

  state_t              state_q;
  kind_t               kind_q;
  logic [N-1:0]        code_q, code_d, step_code;
  logic                falling_q, falling_d, last_step;
  logic [HOLD_W-1:0]   cnt_q, hold_q;
  logic [W-1:0]        y_q, mask;
  logic [N-1:0]        exp_q;
  logic                y_valid_q, bflag_q, busy_q, done_q, ready_q;

  function automatic logic [W-1:0] therm(input logic [N-1:0] k);
    return {W{1'b1}} << k;
  endfunction

  always_comb begin
    mask = '0;
    if (bubble_en && (bubble_pos < CODE_MAX))
      mask = W'(1) << bubble_pos;
  end

  // Next sweep point; the triangle turns around at the top code without repeating it.
  always_comb begin
    code_d    = code_q;
    falling_d = falling_q;
    last_step = 1'b0;
    if (kind_q == K_RAMP) begin
      last_step = (code_q == CODE_MAX);
      code_d    = code_q + 1'b1;
    end else if (!falling_q) begin
      if (code_q == CODE_MAX) begin
        falling_d = 1'b1;
        code_d    = code_q - 1'b1;
      end else begin
        code_d = code_q + 1'b1;
      end
    end else begin
      last_step = (code_q == '0);
      code_d    = code_q - 1'b1;
    end
    step_code = (state_q == S_STEP) ? code_q : code_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      kind_q    <= K_DIRECT;
      code_q    <= '0;
      falling_q <= 1'b0;
      cnt_q     <= '0;
      hold_q    <= '0;
      y_q       <= {W{1'b1}};
      exp_q     <= '0;
      y_valid_q <= 1'b0;
      bflag_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= (mode == 2'd1);
          if (in_valid && ready_q) begin
            y_q       <= therm(in_code) ^ mask;
            exp_q     <= in_code;
            bflag_q   <= |mask;
            y_valid_q <= 1'b1;
            cnt_q     <= hold;
            kind_q    <= K_DIRECT;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
            state_q   <= S_HOLD;
          end else if (start && mode[1]) begin
            code_q    <= '0;
            falling_q <= 1'b0;
            hold_q    <= hold;
            kind_q    <= (mode == 2'd3) ? K_TRI : K_RAMP;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
            state_q   <= S_STEP;
          end
        end
        S_STEP: begin
          y_q       <= therm(step_code) ^ mask;
          exp_q     <= step_code;
          bflag_q   <= |mask;
          y_valid_q <= 1'b1;
          cnt_q     <= hold_q;
          state_q   <= S_HOLD;
        end
        S_HOLD: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (kind_q == K_DIRECT) begin
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= (mode == 2'd1);
            state_q   <= S_IDLE;
          end else if (last_step) begin
            y_valid_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            // Later steps load straight from HOLD so every code lasts exactly hold+1 cycles.
            code_q    <= code_d;
            falling_q <= falling_d;
            y_q       <= therm(step_code) ^ mask;
            exp_q     <= step_code;
            bflag_q   <= |mask;
            cnt_q     <= hold_q;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= (mode == 2'd1);
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Y           = y_q;
  assign exp_code    = exp_q;
  assign y_valid     = y_valid_q;
  assign bubble_flag = bflag_q;
  assign busy        = busy_q;
  assign sweep_done  = done_q;
  assign in_ready    = ready_q;

endmodule

// File: tb/tb_therm_stim_gen.sv
// tb/tb_therm_stim_gen.sv - scoreboard bench for therm_stim_gen
// Stimulus pushes expected patterns; a negedge monitor pops them whenever y_valid is seen.
module tb_therm_stim_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        start = 1'b0;
  logic [3:0]  in_code = 4'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  hold = 8'd0;
  logic        bubble_en = 1'b0;
  logic [3:0]  bubble_pos = 4'd15;
  logic [14:0] Y;
  logic        y_valid;
  logic [3:0]  exp_code;
  logic        bubble_flag;
  logic        busy;
  logic        sweep_done;

  typedef struct packed {
    logic [14:0] y;
    logic [3:0]  c;
    logic        bf;
  } exp_t;

  exp_t exp_q[$];
  int   done_pend = 0;
  int   checks = 0;
  int   errors = 0;

  therm_stim_gen dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .start(start), .in_code(in_code),
    .in_valid(in_valid), .in_ready(in_ready), .hold(hold), .bubble_en(bubble_en),
    .bubble_pos(bubble_pos), .Y(Y), .y_valid(y_valid), .exp_code(exp_code),
    .bubble_flag(bubble_flag), .busy(busy), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [14:0] model_therm(input int k);
    logic [14:0] r;
    for (int b = 0; b < 15; b++) r[b] = (b >= k);
    return r;
  endfunction

  function automatic logic [14:0] model_mask(input logic ben, input int bpos);
    logic [14:0] m;
    m = '0;
    if (ben && bpos < 15) m[bpos] = 1'b1;
    return m;
  endfunction

  task automatic push_code(input int c, input int h, input logic ben, input int bpos);
    exp_t e;
    e.y  = model_therm(c) ^ model_mask(ben, bpos);
    e.c  = 4'(c);
    e.bf = (model_mask(ben, bpos) != '0);
    for (int i = 0; i <= h; i++) exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (y_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'(exp_code), 32'hFFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("Y", 32'(Y), 32'(e.y));
          chk("exp_code", 32'(exp_code), 32'(e.c));
          chk("bubble_flag", 32'(bubble_flag), 32'(e.bf));
        end
      end
      if (sweep_done) begin
        chk("done_expected", 32'(done_pend > 0), 1);
        chk("done_valid_low", 32'(y_valid), 0);
        chk("done_after_last", exp_q.size(), 0);
        if (done_pend > 0) done_pend--;
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", 32'(busy), 0);
  endtask

  task automatic do_direct(input int c, input int h, input logic ben, input int bpos);
    mode = 2'd1;
    @(posedge clk); #1;
    chk("in_ready_idle", 32'(in_ready), 1);
    in_code = 4'(c); hold = 8'(h); bubble_en = ben; bubble_pos = 4'(bpos); in_valid = 1'b1;
    push_code(c, h, ben, bpos);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("direct_lat_valid", 32'(y_valid), 1);
    chk("direct_lat_code", 32'(exp_code), 32'(c));
    chk("direct_lat_Y", 32'(Y), 32'(model_therm(c) ^ model_mask(ben, bpos)));
    wait_idle(h + 10);
    chk("in_ready_after", 32'(in_ready), 1);
    chk("direct_drained", exp_q.size(), 0);
  endtask

  task automatic do_sweep(input int m, input int h, input logic ben, input int bpos, input logic disturb);
    int codes[$];
    for (int k = 0; k <= 15; k++) codes.push_back(k);
    if (m == 3) for (int k = 14; k >= 0; k--) codes.push_back(k);
    mode = 2'(m); hold = 8'(h); bubble_en = ben; bubble_pos = 4'(bpos);
    @(posedge clk); #1;
    foreach (codes[i]) push_code(codes[i], h, ben, bpos);
    done_pend++;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("sweep_busy", 32'(busy), 1);
    if (disturb) begin
      mode = 2'd1; hold = 8'($urandom_range(0, 9)); in_code = 4'($urandom); in_valid = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b0; mode = 2'(m);
    end
    wait_idle(40 * (h + 1) + 20);
    chk("sweep_drained", exp_q.size(), 0);
    chk("sweep_done_seen", done_pend, 0);
    chk("y_retained", 32'(Y), 32'(model_therm(codes[codes.size()-1]) ^ model_mask(ben, bpos)));
  endtask

  initial begin
    int n;
    #12 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_Y", 32'(Y), 32'h7FFF);
    chk("rst_exp_code", 32'(exp_code), 0);
    chk("rst_y_valid", 32'(y_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 0);

    do_direct(8, 0, 1'b0, 0);
    do_sweep(2, 1, 1'b0, 15, 1'b0);
    do_sweep(3, 0, 1'b0, 15, 1'b0);
    do_direct(0, 0, 1'b1, 3);
    do_direct(0, 0, 1'b1, 15);

    mode = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b1; start = 1'b1; in_code = 4'd5;
    @(posedge clk); #1;
    in_valid = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mode0_busy", 32'(busy), 0);
    chk("mode0_valid", 32'(y_valid), 0);

    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 2))
        0: do_direct($urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 15));
        1: do_sweep(2, $urandom_range(0, 2), 1'($urandom), $urandom_range(0, 15), 1'($urandom));
        default: do_sweep(3, $urandom_range(0, 2), 1'($urandom), $urandom_range(0, 15), 1'($urandom));
      endcase
    end

    mode = 2'd2; hold = 8'd1; bubble_en = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k <= 15; k++) push_code(k, 1, 1'b0, 15);
    done_pend++;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(y_valid && exp_code == 4'd7) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_code7", 32'(exp_code), 7);
    #2 rst_n = 1'b0;
    exp_q.delete();
    done_pend = 0;
    #1;
    chk("async_rst_Y", 32'(Y), 32'h7FFF);
    chk("async_rst_exp", 32'(exp_code), 0);
    chk("async_rst_valid", 32'(y_valid), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_flags", {29'd0, bubble_flag, sweep_done, in_ready}, 0);
    #20 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_valid", 32'(y_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
